lsu_io_ctrl: RTL and testbench
==============================

# lsu_io_ctrl

Load/store sequencer between the instruction decoder and the two data-side resources: the synchronous data BRAM and the memory-mapped IO bus at 0xFFFF_xxxx. It takes the decoder's per-instruction access strobes (mem_read/mem_write/io_read/io_write) and drives the byte-lane memory port or the IO handshake. It stalls the core until the access completes, then returns the aligned, sign- or zero-extended load result. The block sits beside the ALU/regfile; its `stall` holds PC and regfile write enable.

## Interface
- DMEM_AW, 14, data BRAM word-address width
- IO_TIMEOUT, 255, IO ack wait limit in cycles (used only with IO_TIMEOUT_EN)
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_read, mem_write, io_read, io_write  in  1 each  decoder strobes, held stable while `stall`=1
- addr  in  32  ALU-computed effective address
- funct3  in  3  size/sign: 0 b, 1 h, 2 w, 4 bu, 5 hu
- wdata  in  32  store data (rs2)
- stall  out  1  core hold request
- done  out  1  one-cycle completion pulse; regfile writes on this edge
- rdata  out  32  load result, valid only while done=1
- err  out  1  misalignment/timeout pulse, coincident with done
- dmem_en, dmem_we[3:0], dmem_addr[DMEM_AW-1:0], dmem_wdata[31:0]  out  BRAM port
- dmem_rdata  in  32  BRAM data, 1-cycle read latency
- io_req, io_we  out  1  IO request/write
- io_addr  out  16  addr[15:0]
- io_wdata[31:0], io_be[3:0]  out
- io_ack  in  1;  io_rdata  in  32

## Operation
- States: IDLE, MEM_RD, IO_REQ, IO_DONE.
- Strobe priority when several are high: io_write > io_read > mem_write > mem_read.
- Misalignment check in IDLE: h/hu with addr[0]=1, or w with addr[1:0]≠0. Response: no access, done=1, err=1, rdata=0, stall=0, stay IDLE.
- Store lanes:
  - b: we=1<<addr[1:0], data = byte replicated ×4.
  - h: we=4'b0011<<addr[1:0], data = half replicated ×2.
  - w: we=4'hF.
  - io_be uses the same rule.
- Load extraction: word >> 8·addr[1:0]. Sign-extend for funct3 0/1; zero-extend for funct3 4/5.
- IDLE + mem_write: dmem_en=1 and dmem_we asserted this cycle, done=1, stall=0, stay IDLE.
- IDLE + mem_read: dmem_en=1, we=0, stall=1, latch addr[1:0]/funct3, go to MEM_RD.
- MEM_RD: rdata formatted from dmem_rdata, done=1, stall=0, go to IDLE.
- IDLE + io_read/io_write: stall=1. Register io_addr, io_wdata, io_be, io_we, addr[1:0], funct3. Go to IO_REQ.
- IO_REQ: io_req=1, stall=1, io_* outputs held constant. On io_ack=1: latch io_rdata, go to IO_DONE.
- IO_DONE: io_req=0, done=1, stall=0, rdata formatted from latched data (0 for writes), go to IDLE.
- io_ack outside IO_REQ is ignored.
- stall = (any strobe high in IDLE and not completing this cycle) or state ∈ {MEM_RD→0, IO_REQ→1}.

## Timing
- Memory store: 1 cycle, 0 stall cycles.
- Memory load: 2 cycles, 1 stall cycle.
- IO access: minimum 3 cycles (IDLE, IO_REQ with same-cycle ack, IO_DONE). Each extra cycle without ack adds one stall cycle.
- Reset: every output is 0 while rst=1 and after it, state=IDLE, latches=0.
- rst during IO_REQ drops io_req at that edge; any later io_ack is ignored.
- done is never high for two consecutive cycles on the same access.

## Configuration
- IO_TIMEOUT_EN defined:
  - An 8+ bit counter (cleared on IO_REQ entry) increments each IO_REQ cycle without ack.
  - On reaching IO_TIMEOUT: drop io_req, go to IO_DONE with err=1, rdata=0.
  - An ack on the same cycle as the timeout wins.
- IO_TIMEOUT_EN undefined: no counter; IO_REQ waits indefinitely; err reports misalignment only.

## Structure
- Shared package `lsu_pkg`:
  - state enum
  - funct3 size constants
  - IO_BASE = 16'hFFFF
  - default IO_TIMEOUT
- Sub-module `lsu_align` (combinational):
  - store lane/data encode
  - load shift and extend
  - misalignment flag
  - Instantiated once for encode and once for decode, or shared.

## Test plan
- sw addr=0x100, wdata=0xDEADBEEF → same cycle: dmem_we=4'hF, dmem_addr=0x40; done=1, stall=0.
- lb addr=0x103, dmem_rdata=0x80AABBCC → cycle 1: stall=1; cycle 2: done=1, rdata=0xFFFFFF80. Same access as lbu → rdata=0x00000080.
- lw addr=0xFFFF_0010, io_ack after 3 IO_REQ cycles with io_rdata=0x1234 → stall high for 4 cycles, then done=1, rdata=0x1234, io_addr=0x0010.
- lh addr=0x101 → done=1, err=1, rdata=0, no dmem_en, no io_req.
- rst asserted in IO_REQ, then io_ack → io_req=0 after the edge; no done; state IDLE.
- With IO_TIMEOUT_EN and IO_TIMEOUT=4, io_ack held 0 → after 4 IO_REQ cycles: done=1, err=1, rdata=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: FSM states, funct3 size codes,
// the IO window base and the default IO ack wait limit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_RD  = 2'd1,
    IO_REQ  = 2'd2,
    IO_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [15:0] IO_BASE            = 16'hFFFF;
  localparam int          IO_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_io_ctrl_if.sv
// Data-side bus bundle of the sequencer: the BRAM byte-lane port and the IO handshake.
// master = sequencer side, slave = memory/IO side.
interface lsu_io_ctrl_if #(
  parameter int DMEM_AW = 14
);
  logic               dmem_en;
  logic [3:0]         dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;

  logic               io_req;
  logic               io_we;
  logic [15:0]        io_addr;
  logic [31:0]        io_wdata;
  logic [3:0]         io_be;
  logic               io_ack;
  logic [31:0]        io_rdata;

  modport master (
    output dmem_en, dmem_we, dmem_addr, dmem_wdata,
    output io_req, io_we, io_addr, io_wdata, io_be,
    input  dmem_rdata, io_ack, io_rdata
  );

  modport slave (
    input  dmem_en, dmem_we, dmem_addr, dmem_wdata,
    input  io_req, io_we, io_addr, io_wdata, io_be,
    output dmem_rdata, io_ack, io_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane helper: store lane/data encode plus misalignment flag on
// the live request, and load shift/extend on the latched offset and size.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  enc_funct3,
  input  logic [1:0]  enc_off,
  input  logic [31:0] store_data,
  output logic        misaligned,
  output logic [3:0]  lane_we,
  output logic [31:0] lane_data,
  input  logic [2:0]  dec_funct3,
  input  logic [1:0]  dec_off,
  input  logic [31:0] load_word,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    misaligned = (((enc_funct3 == F3_H) || (enc_funct3 == F3_HU)) && enc_off[0]) ||
                 ((enc_funct3 == F3_W) && (enc_off != 2'd0));
    // Replicated data lets the lane enables alone pick the bytes that land.
    case (enc_funct3[1:0])
      2'b00: begin
        lane_we   = 4'b0001 << enc_off;
        lane_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        lane_we   = 4'b0011 << enc_off;
        lane_data = {2{store_data[15:0]}};
      end
      default: begin
        lane_we   = 4'hF;
        lane_data = store_data;
      end
    endcase
  end

  always_comb begin
    shifted = load_word >> {dec_off, 3'b000};
    case (dec_funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_io_ctrl.sv
// Load/store sequencer between the decoder and the data BRAM / IO bus; stalls the core
// until the access completes. Define IO_TIMEOUT_EN to bound the IO ack wait by IO_TIMEOUT.
module lsu_io_ctrl
  import lsu_pkg::*;
#(
  parameter int DMEM_AW    = 14,
  parameter int IO_TIMEOUT = IO_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic         io_read,
  input  logic         io_write,
  input  logic [31:0]  addr,
  input  logic [2:0]   funct3,
  input  logic [31:0]  wdata,
  output logic         stall,
  output logic         done,
  output logic [31:0]  rdata,
  output logic         err,
  lsu_io_ctrl_if.master bus
);

  lsu_state_e  state_reg, state_next;
  logic [1:0]  off_reg;
  logic [2:0]  f3_reg;
  logic [15:0] io_addr_reg;
  logic [31:0] io_wdata_reg;
  logic [3:0]  io_be_reg;
  logic        io_we_reg;
  logic [31:0] io_data_reg;

  logic        latch_io, latch_rd, take_ack;
  logic        misaligned;
  logic [3:0]  lane_we;
  logic [31:0] lane_data, load_word, load_data;

  wire unused_addr_hi = ^addr[31:16];

`ifdef IO_TIMEOUT_EN
  localparam int TO_W = ($clog2(IO_TIMEOUT + 1) > 8) ? $clog2(IO_TIMEOUT + 1) : 8;
  logic [TO_W-1:0] to_cnt_reg;
  logic            to_flag_reg;
  logic            to_hit;
`else
  localparam int unused_io_timeout = IO_TIMEOUT;
`endif

  assign load_word = (state_reg == MEM_RD) ? bus.dmem_rdata : io_data_reg;

  lsu_align u_align (
    .enc_funct3 (funct3),
    .enc_off    (addr[1:0]),
    .store_data (wdata),
    .misaligned (misaligned),
    .lane_we    (lane_we),
    .lane_data  (lane_data),
    .dec_funct3 (f3_reg),
    .dec_off    (off_reg),
    .load_word  (load_word),
    .load_data  (load_data)
  );

  always_comb begin
    state_next      = state_reg;
    latch_io        = 1'b0;
    latch_rd        = 1'b0;
    take_ack        = 1'b0;
`ifdef IO_TIMEOUT_EN
    to_hit          = 1'b0;
`endif
    stall           = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    rdata           = '0;
    bus.dmem_en     = 1'b0;
    bus.dmem_we     = '0;
    bus.dmem_addr   = '0;
    bus.dmem_wdata  = '0;
    bus.io_req      = 1'b0;
    bus.io_we       = 1'b0;
    bus.io_addr     = '0;
    bus.io_wdata    = '0;
    bus.io_be       = '0;

    // Reset forces every output low even while strobes are asserted.
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (io_write || io_read || mem_write || mem_read) begin
            if (misaligned) begin
              done = 1'b1;
              err  = 1'b1;
            end else if (io_write || io_read) begin
              stall      = 1'b1;
              latch_io   = 1'b1;
              state_next = IO_REQ;
            end else if (mem_write) begin
              bus.dmem_en    = 1'b1;
              bus.dmem_we    = lane_we;
              bus.dmem_addr  = addr[DMEM_AW+1:2];
              bus.dmem_wdata = lane_data;
              done           = 1'b1;
            end else begin
              bus.dmem_en   = 1'b1;
              bus.dmem_addr = addr[DMEM_AW+1:2];
              stall         = 1'b1;
              latch_rd      = 1'b1;
              state_next    = MEM_RD;
            end
          end
        end
        MEM_RD: begin
          done       = 1'b1;
          rdata      = load_data;
          state_next = IDLE;
        end
        IO_REQ: begin
          stall        = 1'b1;
          bus.io_req   = 1'b1;
          bus.io_we    = io_we_reg;
          bus.io_addr  = io_addr_reg;
          bus.io_wdata = io_wdata_reg;
          bus.io_be    = io_be_reg;
          if (bus.io_ack) begin
            take_ack   = 1'b1;
            state_next = IO_DONE;
`ifdef IO_TIMEOUT_EN
          end else if (to_cnt_reg == TO_W'(IO_TIMEOUT - 1)) begin
            to_hit     = 1'b1;
            state_next = IO_DONE;
`endif
          end
        end
        default: begin
          done       = 1'b1;
          rdata      = io_we_reg ? '0 : load_data;
`ifdef IO_TIMEOUT_EN
          err        = to_flag_reg;
`endif
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      off_reg      <= '0;
      f3_reg       <= '0;
      io_addr_reg  <= '0;
      io_wdata_reg <= '0;
      io_be_reg    <= '0;
      io_we_reg    <= 1'b0;
      io_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (latch_io || latch_rd) begin
        off_reg <= addr[1:0];
        f3_reg  <= funct3;
      end
      if (latch_io) begin
        io_addr_reg  <= addr[15:0];
        io_wdata_reg <= lane_data;
        io_be_reg    <= lane_we;
        io_we_reg    <= io_write;
      end
      if (take_ack) io_data_reg <= bus.io_rdata;
`ifdef IO_TIMEOUT_EN
      if (to_hit) io_data_reg <= '0;
`endif
    end
  end

`ifdef IO_TIMEOUT_EN
  // Counts IO_REQ cycles without ack; an ack on the limit cycle takes precedence.
  always_ff @(posedge clk) begin
    if (rst || latch_io) begin
      to_cnt_reg  <= '0;
      to_flag_reg <= 1'b0;
    end else if ((state_reg == IO_REQ) && !take_ack) begin
      to_cnt_reg  <= to_cnt_reg + TO_W'(1);
      to_flag_reg <= to_hit;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_io_ctrl.sv
// Directed plus randomized bench for lsu_io_ctrl against a byte-addressed reference model.
module tb_lsu_io_ctrl;
  import lsu_pkg::*;

`ifdef IO_TIMEOUT_EN
  localparam int TB_TO = 4;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TB_TO = 255;
  localparam bit TO_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write, io_read, io_write;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic        stall, done, err;
  logic [31:0] rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int n_txn  = 0;

  logic [7:0]  ref_bytes [0:65535];
  logic [31:0] mem       [0:16383];
  logic        mem_ready;

  lsu_io_ctrl_if #(.DMEM_AW(14)) bus ();

  lsu_io_ctrl #(.DMEM_AW(14), .IO_TIMEOUT(TB_TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .io_read   (io_read),
    .io_write  (io_write),
    .addr      (addr),
    .funct3    (funct3),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // Synchronous BRAM with one-cycle read latency, preloaded once from pat().
  always @(posedge clk) begin
    if (rst && !mem_ready) begin
      for (int i = 0; i < 16384; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
      bus.dmem_rdata <= '0;
    end else if (!rst && bus.dmem_en) begin
      for (int j = 0; j < 4; j++)
        if (bus.dmem_we[j]) mem[bus.dmem_addr][8*j +: 8] <= bus.dmem_wdata[8*j +: 8];
      bus.dmem_rdata <= mem[bus.dmem_addr];
    end
  end

  function automatic logic [31:0] ext(input logic [31:0] v, input logic [2:0] f3);
    logic [31:0] b, h;
    b = v & 32'h0000_00FF;
    h = v & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)    ? b - 32'd256     : b;
      3'd1:    return (h >= 32'h8000)   ? h - 32'h10000   : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return v;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mask = {io_write, io_read, mem_write, mem_read}; the model resolves priority itself.
  task automatic run_access(input logic [3:0] mask, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] wd, input int wait_n, input logic [31:0] io_rd);
    int          kind, nbytes, last, base;
    logic [1:0]  off;
    logic [3:0]  lanes;
    logic [31:0] sdata, val, exp_rd;
    bit          mis, timed_out;

    kind   = mask[3] ? 2 : mask[2] ? 3 : mask[1] ? 0 : 1;
    off    = a[1:0];
    base   = int'(a[15:0]);
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis    = (nbytes == 2 && a[0]) || (nbytes == 4 && off != 2'd0);
    lanes  = 4'(((1 << nbytes) - 1) << off);
    sdata  = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;
    timed_out = (kind >= 2) && TO_ON && (wait_n >= TB_TO);
    last      = timed_out ? TB_TO - 1 : wait_n;

    @(negedge clk);
    {io_write, io_read, mem_write, mem_read} = mask;
    addr = a; funct3 = f3; wdata = wd;
    #1;
    if (mis) begin
      chk("mis_done",   32'(done),        32'd1);
      chk("mis_err",    32'(err),         32'd1);
      chk("mis_rdata",  rdata,            32'd0);
      chk("mis_stall",  32'(stall),       32'd0);
      chk("mis_dmem",   32'(bus.dmem_en), 32'd0);
      chk("mis_ioreq",  32'(bus.io_req),  32'd0);
    end else if (kind == 0) begin
      chk("st_en",    32'(bus.dmem_en),   32'd1);
      chk("st_we",    32'(bus.dmem_we),   32'(lanes));
      chk("st_addr",  32'(bus.dmem_addr), 32'(a[15:2]));
      chk("st_wdata", bus.dmem_wdata,     sdata);
      chk("st_done",  32'(done),          32'd1);
      chk("st_stall", 32'(stall),         32'd0);
      for (int k = 0; k < nbytes; k++) ref_bytes[base + k] = wd[8*k +: 8];
    end else if (kind == 1) begin
      val = '0;
      for (int k = 0; k < nbytes; k++) val = val | (32'(ref_bytes[base + k]) << (8*k));
      exp_rd = ext(val, f3);
      chk("ld_stall1", 32'(stall),         32'd1);
      chk("ld_done1",  32'(done),          32'd0);
      chk("ld_en",     32'(bus.dmem_en),   32'd1);
      chk("ld_we",     32'(bus.dmem_we),   32'd0);
      chk("ld_addr",   32'(bus.dmem_addr), 32'(a[15:2]));
      @(negedge clk); #1;
      chk("ld_done",   32'(done),  32'd1);
      chk("ld_stall",  32'(stall), 32'd0);
      chk("ld_err",    32'(err),   32'd0);
      chk("ld_rdata",  rdata,      exp_rd);
    end else begin
      chk("io_stall0", 32'(stall),      32'd1);
      chk("io_done0",  32'(done),       32'd0);
      chk("io_req0",   32'(bus.io_req), 32'd0);
      for (int c = 0; c <= last; c++) begin
        @(negedge clk);
        bus.io_ack   = (!timed_out && c == wait_n);
        bus.io_rdata = bus.io_ack ? io_rd : ~io_rd;
        #1;
        chk("io_req",   32'(bus.io_req),  32'd1);
        chk("io_stall", 32'(stall),       32'd1);
        chk("io_done",  32'(done),        32'd0);
        chk("io_addr",  32'(bus.io_addr), 32'(a[15:0]));
        chk("io_be",    32'(bus.io_be),   32'(lanes));
        chk("io_we",    32'(bus.io_we),   (kind == 2) ? 32'd1 : 32'd0);
        if (kind == 2) chk("io_wdata", bus.io_wdata, sdata);
      end
      @(negedge clk);
      bus.io_ack   = 1'b0;
      bus.io_rdata = $urandom;
      #1;
      exp_rd = (kind == 2 || timed_out) ? 32'd0 : ext(io_rd >> (8*off), f3);
      chk("iod_done",  32'(done),       32'd1);
      chk("iod_stall", 32'(stall),      32'd0);
      chk("iod_req",   32'(bus.io_req), 32'd0);
      chk("iod_err",   32'(err),        timed_out ? 32'd1 : 32'd0);
      chk("iod_rdata", rdata,           exp_rd);
    end
    @(negedge clk);
    {io_write, io_read, mem_write, mem_read} = 4'b0000;
    #1;
    chk("idle_done",  32'(done),  32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    $display("txn %0d strobes=%b addr=%h f3=%0d wdata=%h wait=%0d", n_txn, mask, a, f3, wd, wait_n);
    n_txn++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t reached, required finish before 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w, a;
    logic [3:0]  m;
    logic [2:0]  f3;
    int          sel;
    logic [2:0]  ld_codes [5];

    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    mem_ready = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      w = pat(i);
      for (int j = 0; j < 4; j++) ref_bytes[4*i + j] = w[8*j +: 8];
    end

    rst = 1'b1;
    {io_write, io_read, mem_write} = 3'b000;
    mem_read = 1'b1;
    addr = 32'h0000_0100; funct3 = 3'd2; wdata = '0;
    bus.io_ack = 1'b0; bus.io_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall),         32'd0);
    chk("rst_done",  32'(done),          32'd0);
    chk("rst_err",   32'(err),           32'd0);
    chk("rst_rdata", rdata,              32'd0);
    chk("rst_dmem",  32'(bus.dmem_en),   32'd0);
    chk("rst_ioreq", 32'(bus.io_req),    32'd0);
    chk("rst_ioadr", 32'(bus.io_addr),   32'd0);
    chk("rst_iobe",  32'(bus.io_be),     32'd0);
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;

    run_access(4'b0010, 32'h0000_0100, 3'd2, 32'hDEADBEEF, 0, 0);
    run_access(4'b0010, 32'h0000_0100, 3'd2, 32'h80AABBCC, 0, 0);
    run_access(4'b0001, 32'h0000_0103, 3'd0, 0, 0, 0);
    run_access(4'b0001, 32'h0000_0103, 3'd4, 0, 0, 0);
    run_access(4'b0100, {IO_BASE, 16'h0010}, 3'd2, 0, 2, 32'h0000_1234);
    run_access(4'b0001, 32'h0000_0101, 3'd1, 0, 0, 0);
    run_access(4'b0100, {IO_BASE, 16'h0004}, 3'd2, 0, 6, 32'hCAFE_0000);
    run_access(4'b1001, {IO_BASE, 16'h0022}, 3'd1, 32'h0000_BEEF, 1, 0);
    run_access(4'b0011, 32'h0000_0206, 3'd1, 32'h0000_8001, 0, 0);
    run_access(4'b0001, 32'h0000_0206, 3'd1, 0, 0, 0);

    // Reset while waiting for an IO ack; a late ack must not complete anything.
    @(negedge clk);
    io_read = 1'b1; addr = {IO_BASE, 16'h0040}; funct3 = 3'd2;
    #1 chk("rio_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    chk("rio_req", 32'(bus.io_req), 32'd1);
    rst = 1'b1; io_read = 1'b0;
    #1 chk("rio_req_rst", 32'(bus.io_req), 32'd0);
    @(negedge clk); #1;
    chk("rio_req_after", 32'(bus.io_req), 32'd0);
    chk("rio_done",      32'(done),       32'd0);
    rst = 1'b0; bus.io_ack = 1'b1; bus.io_rdata = 32'h0000_0055;
    @(negedge clk); #1;
    chk("rio_ack_req",   32'(bus.io_req), 32'd0);
    chk("rio_ack_done",  32'(done),       32'd0);
    chk("rio_ack_stall", 32'(stall),      32'd0);
    bus.io_ack = 1'b0;
    run_access(4'b0001, 32'h0000_0100, 3'd2, 0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      m = 4'($urandom_range(1, 15));
      if (m[3] || m[2]) a = {IO_BASE, 16'($urandom)};
      else              a = 32'($urandom_range(0, 4095));
      sel = $urandom_range(0, 4);
      if ((m[3] || (!m[2] && m[1])) && sel > 2) sel = sel - 3;
      f3 = ld_codes[sel];
      run_access(m, a, f3, $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
